// File: rtl/moldudp64_multi_parser.sv
`default_nettype none
// ============================================================================
// moldudp64_multi_parser - Eth/IPv4/UDP/MoldUDP64 parser with per-channel
// sequence tracking, duplicate drop, gap reporting and ITCH message framing.
// Revision: 1.0
// ============================================================================
module moldudp64_multi_parser #(
  parameter int                  NUM_CH          = 2,
  parameter logic [NUM_CH*16-1:0] CH_PORTS       = {16'd26401, 16'd26400},
  parameter bit                  CHECK_ETHERTYPE = 1'b1,
  localparam int                 CH_W            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic            clkIn,
  input  logic            rstIn,
  input  logic [7:0]      dataIn,
  input  logic            dataValidIn,
  input  logic            dataLastIn,
  input  logic            dataErrIn,
  output logic            itchDataValidOut,
  output logic [7:0]      itchDataOut,
  output logic            itchStartOut,
  output logic            itchEndOut,
  output logic            itchErrOut,
  output logic [CH_W-1:0] itchChOut,
  output logic            packetLostOut,
  output logic [15:0]     lostCountOut,
  output logic [15:0]     droppedPktsOut
);

  typedef enum logic [2:0] {
    S_HDR    = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_BODY   = 3'd3,
    S_SKIP   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [5:0]      hdr_cnt_q, hdr_cnt_d;
  logic [7:0]      eth_hi_q, eth_hi_d;
  logic [7:0]      port_hi_q, port_hi_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [63:0]     seq_q, seq_d;
  logic [7:0]      cnt_hi_q, cnt_hi_d;
  logic [15:0]     msg_remain_q, msg_remain_d;
  logic [7:0]      len_hi_q, len_hi_d;
  logic [15:0]     msg_len_q, msg_len_d;
  logic [15:0]     body_cnt_q, body_cnt_d;
  logic [63:0]     exp_seq_q [NUM_CH];
  logic [63:0]     exp_seq_d [NUM_CH];
  logic [NUM_CH-1:0] seen_q, seen_d;

  logic            itch_valid_q, itch_valid_d;
  logic [7:0]      itch_data_q, itch_data_d;
  logic            itch_start_q, itch_start_d;
  logic            itch_end_q, itch_end_d;
  logic            itch_err_q, itch_err_d;
  logic [CH_W-1:0] itch_ch_q, itch_ch_d;
  logic            packet_lost_q, packet_lost_d;
  logic [15:0]     lost_count_q, lost_count_d;
  logic [15:0]     dropped_q, dropped_d;

  logic            port_hit;
  logic [CH_W-1:0] port_ch;
  logic            check_ok;
  logic            drop;
  logic            term;
  logic            is_end;
  logic [15:0]     count_w;
  logic [15:0]     len_w;
  logic [63:0]     diff_w;

  // Reverse scan so the lowest matching channel index wins.
  always_comb begin
    port_hit = 1'b0;
    port_ch  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (CH_PORTS[16*i +: 16] == {port_hi_q, dataIn}) begin
        port_hit = 1'b1;
        port_ch  = CH_W'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    hdr_cnt_d    = hdr_cnt_q;
    eth_hi_d     = eth_hi_q;
    port_hi_d    = port_hi_q;
    ch_d         = ch_q;
    seq_d        = seq_q;
    cnt_hi_d     = cnt_hi_q;
    msg_remain_d = msg_remain_q;
    len_hi_d     = len_hi_q;
    msg_len_d    = msg_len_q;
    body_cnt_d   = body_cnt_q;
    exp_seq_d    = exp_seq_q;
    seen_d       = seen_q;
    itch_valid_d  = 1'b0;
    itch_data_d   = itch_data_q;
    itch_start_d  = 1'b0;
    itch_end_d    = 1'b0;
    itch_err_d    = 1'b0;
    itch_ch_d     = itch_ch_q;
    packet_lost_d = 1'b0;
    lost_count_d  = 16'd0;
    dropped_d     = dropped_q;
    check_ok = 1'b1;
    drop     = 1'b0;
    term     = dataLastIn || dataErrIn;
    count_w  = {cnt_hi_q, dataIn};
    len_w    = {len_hi_q, dataIn};
    diff_w   = seq_q - exp_seq_q[ch_q];
    is_end   = (body_cnt_q + 16'd1) == msg_len_q;

    if (dataValidIn) begin
      case (state_q)
        S_HDR: begin
          hdr_cnt_d = hdr_cnt_q + 6'd1;
          case (hdr_cnt_q)
            6'd12: eth_hi_d = dataIn;
            6'd13: if (CHECK_ETHERTYPE && ({eth_hi_q, dataIn} != 16'h0800)) check_ok = 1'b0;
            6'd14: if (dataIn != 8'h45) check_ok = 1'b0;
            6'd23: if (dataIn != 8'd17) check_ok = 1'b0;
            6'd36: port_hi_d = dataIn;
            6'd37: begin
              if (!port_hit) check_ok = 1'b0;
              ch_d = port_ch;
            end
            6'd52, 6'd53, 6'd54, 6'd55,
            6'd56, 6'd57, 6'd58, 6'd59: seq_d = {seq_q[55:0], dataIn};
            6'd60: cnt_hi_d = dataIn;
            default: ;
          endcase

          if (!check_ok || term) begin
            drop      = 1'b1;
            hdr_cnt_d = 6'd0;
            state_d   = dataLastIn ? S_HDR : S_SKIP;
          end else if (hdr_cnt_q == 6'd61) begin
            hdr_cnt_d = 6'd0;
            if (count_w == 16'hFFFF) begin
              state_d = S_SKIP;
            end else if (seen_q[ch_q] && (seq_q < exp_seq_q[ch_q])) begin
              state_d = S_SKIP;
            end else begin
              if (seen_q[ch_q] && (seq_q != exp_seq_q[ch_q])) begin
                packet_lost_d = 1'b1;
                lost_count_d  = (|diff_w[63:16]) ? 16'hFFFF : diff_w[15:0];
                itch_ch_d     = ch_q;
              end
              exp_seq_d[ch_q] = seq_q + {48'd0, count_w};
              seen_d[ch_q]    = 1'b1;
              msg_remain_d    = count_w;
              state_d         = (count_w == 16'd0) ? S_SKIP : S_LEN_HI;
            end
          end
        end

        S_LEN_HI, S_LEN_LO: begin
          if (term) begin
            itch_err_d = 1'b1;
            itch_ch_d  = ch_q;
            state_d    = dataLastIn ? S_HDR : S_SKIP;
          end else if (state_q == S_LEN_HI) begin
            len_hi_d = dataIn;
            state_d  = S_LEN_LO;
          end else if (len_w == 16'd0) begin
            msg_remain_d = msg_remain_q - 16'd1;
            state_d      = (msg_remain_q == 16'd1) ? S_SKIP : S_LEN_HI;
          end else begin
            msg_len_d  = len_w;
            body_cnt_d = 16'd0;
            state_d    = S_BODY;
          end
        end

        S_BODY: begin
          // A last flag on the final message byte is a clean frame end.
          if (dataErrIn || (dataLastIn && !is_end)) begin
            itch_err_d = 1'b1;
            itch_ch_d  = ch_q;
            state_d    = dataLastIn ? S_HDR : S_SKIP;
          end else begin
            itch_valid_d = 1'b1;
            itch_data_d  = dataIn;
            itch_start_d = (body_cnt_q == 16'd0);
            itch_end_d   = is_end;
            itch_ch_d    = ch_q;
            body_cnt_d   = body_cnt_q + 16'd1;
            if (is_end) begin
              msg_remain_d = msg_remain_q - 16'd1;
              if (dataLastIn)                 state_d = S_HDR;
              else if (msg_remain_q == 16'd1) state_d = S_SKIP;
              else                            state_d = S_LEN_HI;
            end
          end
        end

        S_SKIP: begin
          if (dataLastIn) state_d = S_HDR;
        end

        default: state_d = S_HDR;
      endcase
    end

    if (drop && (dropped_q != 16'hFFFF)) dropped_d = dropped_q + 16'd1;
  end

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      state_q       <= S_HDR;
      hdr_cnt_q     <= 6'd0;
      eth_hi_q      <= 8'd0;
      port_hi_q     <= 8'd0;
      ch_q          <= '0;
      seq_q         <= 64'd0;
      cnt_hi_q      <= 8'd0;
      msg_remain_q  <= 16'd0;
      len_hi_q      <= 8'd0;
      msg_len_q     <= 16'd0;
      body_cnt_q    <= 16'd0;
      for (int i = 0; i < NUM_CH; i++) exp_seq_q[i] <= 64'd0;
      seen_q        <= '0;
      itch_valid_q  <= 1'b0;
      itch_data_q   <= 8'd0;
      itch_start_q  <= 1'b0;
      itch_end_q    <= 1'b0;
      itch_err_q    <= 1'b0;
      itch_ch_q     <= '0;
      packet_lost_q <= 1'b0;
      lost_count_q  <= 16'd0;
      dropped_q     <= 16'd0;
    end else begin
      state_q       <= state_d;
      hdr_cnt_q     <= hdr_cnt_d;
      eth_hi_q      <= eth_hi_d;
      port_hi_q     <= port_hi_d;
      ch_q          <= ch_d;
      seq_q         <= seq_d;
      cnt_hi_q      <= cnt_hi_d;
      msg_remain_q  <= msg_remain_d;
      len_hi_q      <= len_hi_d;
      msg_len_q     <= msg_len_d;
      body_cnt_q    <= body_cnt_d;
      exp_seq_q     <= exp_seq_d;
      seen_q        <= seen_d;
      itch_valid_q  <= itch_valid_d;
      itch_data_q   <= itch_data_d;
      itch_start_q  <= itch_start_d;
      itch_end_q    <= itch_end_d;
      itch_err_q    <= itch_err_d;
      itch_ch_q     <= itch_ch_d;
      packet_lost_q <= packet_lost_d;
      lost_count_q  <= lost_count_d;
      dropped_q     <= dropped_d;
    end
  end

  assign itchDataValidOut = itch_valid_q;
  assign itchDataOut      = itch_data_q;
  assign itchStartOut     = itch_start_q;
  assign itchEndOut       = itch_end_q;
  assign itchErrOut       = itch_err_q;
  assign itchChOut        = itch_ch_q;
  assign packetLostOut    = packet_lost_q;
  assign lostCountOut     = lost_count_q;
  assign droppedPktsOut   = dropped_q;

endmodule
`default_nettype wire

// File: tb/tb_moldudp64_multi_parser.sv
`default_nettype none
// ============================================================================
// tb_moldudp64_multi_parser - directed self-checking bench for the parser.
// Revision: 1.0
// ============================================================================
module tb_moldudp64_multi_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_in;
  logic        valid_in, last_in, err_in;
  logic        o_valid, o_start, o_end, o_err, o_lost;
  logic [7:0]  o_data;
  logic [0:0]  o_ch;
  logic [15:0] o_lost_cnt, o_dropped;

  always #2 clk = ~clk;

  moldudp64_multi_parser dut (
    .clkIn(clk), .rstIn(rst),
    .dataIn(data_in), .dataValidIn(valid_in), .dataLastIn(last_in), .dataErrIn(err_in),
    .itchDataValidOut(o_valid), .itchDataOut(o_data), .itchStartOut(o_start),
    .itchEndOut(o_end), .itchErrOut(o_err), .itchChOut(o_ch),
    .packetLostOut(o_lost), .lostCountOut(o_lost_cnt), .droppedPktsOut(o_dropped)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] q_data[$];
  logic       q_start[$];
  logic       q_end[$];
  logic       q_ch[$];
  int         err_cnt, lost_cnt;
  logic [15:0] lost_val;
  logic        lost_ch;
  logic [7:0]  fq[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (o_valid) begin
      q_data.push_back(o_data);
      q_start.push_back(o_start);
      q_end.push_back(o_end);
      q_ch.push_back(o_ch);
    end
    if (o_err) err_cnt++;
    if (o_lost) begin
      lost_cnt++;
      lost_val = o_lost_cnt;
      lost_ch  = o_ch;
    end
  end

  task automatic clear_mon();
    q_data.delete(); q_start.delete(); q_end.delete(); q_ch.delete();
    err_cnt = 0; lost_cnt = 0; lost_val = 16'd0; lost_ch = 1'b0;
  endtask

  function automatic logic [31:0] pack_data();
    logic [31:0] v = 32'd0;
    foreach (q_data[i]) v = {v[23:0], q_data[i]};
    return v;
  endfunction

  function automatic logic [7:0] pack_flags(input bit sel_end);
    logic [7:0] v = 8'd0;
    foreach (q_start[i]) v = {v[6:0], sel_end ? q_end[i] : q_start[i]};
    return v;
  endfunction

  task automatic build_hdr(input logic [15:0] eth, input logic [7:0] ihl,
                           input logic [15:0] port, input logic [63:0] seq,
                           input logic [15:0] cnt);
    logic [7:0] b;
    fq.delete();
    for (int i = 0; i < 62; i++) begin
      b = 8'(i) ^ 8'h5A;
      if (i == 12) b = eth[15:8];
      if (i == 13) b = eth[7:0];
      if (i == 14) b = ihl;
      if (i == 23) b = 8'd17;
      if (i == 36) b = port[15:8];
      if (i == 37) b = port[7:0];
      if (i >= 52 && i <= 59) b = seq[8*(59-i) +: 8];
      if (i == 60) b = cnt[15:8];
      if (i == 61) b = cnt[7:0];
      fq.push_back(b);
    end
  endtask

  // d holds the message bytes left-aligned, first byte in d[39:32].
  task automatic add_msg(input int len, input logic [39:0] d);
    fq.push_back(8'(len >> 8));
    fq.push_back(8'(len));
    for (int k = 0; k < len; k++) fq.push_back(d[39-8*k -: 8]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      valid_in = 1'b0; last_in = 1'b0; err_in = 1'b0;
    end
  endtask

  // Send the first n bytes of fq (n<=0 means all plus 4 FCS bytes).
  task automatic send(input int n, input bit with_last);
    int total;
    if (n <= 0) begin
      repeat (4) fq.push_back(8'hF5);
      total = fq.size();
    end else begin
      total = n;
    end
    for (int i = 0; i < total; i++) begin
      if (i % 7 == 3) idle(1);
      @(posedge clk); #1;
      data_in = fq[i]; valid_in = 1'b1; err_in = 1'b0;
      last_in = with_last && (i == total - 1);
    end
    idle(4);
  endtask

  localparam logic [15:0] P0 = 16'd26400;
  localparam logic [15:0] P1 = 16'd26401;

  initial begin
    rst = 1'b1; data_in = 8'd0; valid_in = 1'b0; last_in = 1'b0; err_in = 1'b0;
    clear_mon();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", o_valid, 0);
    chk("rst_lost", o_lost, 0);
    chk("rst_dropped", o_dropped, 0);
    chk("rst_err", o_err, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Ch0 first packet: two messages
    clear_mon();
    build_hdr(16'h0800, 8'h45, P0, 64'd1, 16'd2);
    add_msg(3, 40'hAABBCC0000); add_msg(1, 40'hDD00000000);
    send(0, 1'b1);
    chk("t1_nbytes", q_data.size(), 4);
    chk("t1_data", pack_data(), 32'hAABBCCDD);
    chk("t1_start", pack_flags(0), 8'b1001);
    chk("t1_end", pack_flags(1), 8'b0011);
    chk("t1_ch", q_ch[0] | q_ch[3], 0);
    chk("t1_lost", lost_cnt, 0);

    // Gap: expSeq0=3, seq=7 -> lost 4
    clear_mon();
    build_hdr(16'h0800, 8'h45, P0, 64'd7, 16'd1);
    add_msg(2, 40'h1122000000);
    send(0, 1'b1);
    chk("t2_lost_pulses", lost_cnt, 1);
    chk("t2_lost_val", lost_val, 16'd4);
    chk("t2_lost_ch", lost_ch, 0);
    chk("t2_data", pack_data(), 32'h1122);

    // Duplicate replay
    clear_mon();
    build_hdr(16'h0800, 8'h45, P0, 64'd3, 16'd1);
    add_msg(1, 40'h9900000000);
    send(0, 1'b1);
    chk("t3_nbytes", q_data.size(), 0);
    chk("t3_dropped", o_dropped, 0);
    chk("t3_lost", lost_cnt, 0);

    // Ch1 first packet
    clear_mon();
    build_hdr(16'h0800, 8'h45, P1, 64'd100, 16'd1);
    add_msg(1, 40'hEE00000000);
    send(0, 1'b1);
    chk("t4_nbytes", q_data.size(), 1);
    chk("t4_ch", q_ch[0], 1);
    chk("t4_lost", lost_cnt, 0);

    // Ch0 continues at 8 with no gap
    clear_mon();
    build_hdr(16'h0800, 8'h45, P0, 64'd8, 16'd1);
    add_msg(1, 40'h7700000000);
    send(0, 1'b1);
    chk("t5_lost", lost_cnt, 0);
    chk("t5_data", pack_data(), 32'h77);
    chk("t5_ch", q_ch[0], 0);

    // Filtered frames
    clear_mon();
    build_hdr(16'h86DD, 8'h45, P0, 64'd9, 16'd1); add_msg(1, 40'h01);
    send(0, 1'b1);
    chk("t6_drop_eth", o_dropped, 1);
    build_hdr(16'h0800, 8'h45, 16'd1234, 64'd9, 16'd1); add_msg(1, 40'h01);
    send(0, 1'b1);
    chk("t6_drop_port", o_dropped, 2);
    build_hdr(16'h0800, 8'h46, P0, 64'd9, 16'd1); add_msg(1, 40'h01);
    send(0, 1'b1);
    chk("t6_drop_ihl", o_dropped, 3);
    chk("t6_nbytes", q_data.size(), 0);

    // Truncation at body byte 2 of L=5
    clear_mon();
    build_hdr(16'h0800, 8'h45, P0, 64'd9, 16'd1);
    add_msg(5, 40'h4142434445);
    send(66, 1'b1);
    chk("t7_err", err_cnt, 1);
    chk("t7_nbytes", q_data.size(), 1);
    chk("t7_end", pack_flags(1), 0);
    chk("t7_start", pack_flags(0), 1);
    clear_mon();
    build_hdr(16'h0800, 8'h45, P0, 64'd10, 16'd1);
    add_msg(2, 40'h3132000000);
    send(0, 1'b1);
    chk("t7b_lost", lost_cnt, 0);
    chk("t7b_data", pack_data(), 32'h3132);
    chk("t7b_end", pack_flags(1), 8'b01);

    // Heartbeat, gap on ch1, saturated gap
    clear_mon();
    build_hdr(16'h0800, 8'h45, P1, 64'd101, 16'd0);
    send(0, 1'b1);
    chk("t8_hb_nbytes", q_data.size(), 0);
    chk("t8_hb_lost", lost_cnt, 0);
    build_hdr(16'h0800, 8'h45, P1, 64'd105, 16'd1);
    add_msg(1, 40'h6600000000);
    send(0, 1'b1);
    chk("t8_lost_val", lost_val, 16'd4);
    chk("t8_lost_ch", lost_ch, 1);
    clear_mon();
    build_hdr(16'h0800, 8'h45, P1, 64'd106 + 64'h20000, 16'd0);
    send(0, 1'b1);
    chk("t8_sat", lost_val, 16'hFFFF);

    // End-of-session, then zero-length message
    clear_mon();
    build_hdr(16'h0800, 8'h45, P0, 64'd12, 16'hFFFF);
    send(0, 1'b1);
    chk("t9_eos_nbytes", q_data.size(), 0);
    chk("t9_eos_lost", lost_cnt, 0);
    build_hdr(16'h0800, 8'h45, P0, 64'd11, 16'd2);
    add_msg(0, 40'h0); add_msg(1, 40'h5A00000000);
    send(0, 1'b1);
    chk("t9_lost", lost_cnt, 0);
    chk("t9_data", pack_data(), 32'h5A);
    chk("t9_flags", {pack_flags(0), pack_flags(1)}, 16'h0101);

    // Reset in the middle of a message body
    clear_mon();
    build_hdr(16'h0800, 8'h45, P0, 64'd13, 16'd1);
    add_msg(4, 40'h8182838400);
    send(66, 1'b0);
    chk("t10_pre_nbytes", q_data.size(), 2);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t10_valid", o_valid, 0);
    chk("t10_dropped", o_dropped, 0);
    chk("t10_ch", o_ch, 0);
    clear_mon();
    build_hdr(16'h0800, 8'h45, P0, 64'd50, 16'd1);
    add_msg(1, 40'hC300000000);
    send(0, 1'b1);
    chk("t10_seen_cleared", lost_cnt, 0);
    chk("t10_data", pack_data(), 32'hC3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/moldudp64_multi_parser.md
Name: moldudp64_multi_parser

Overview:
- Parametrised successor to the single-feed Eth/IP/UDP/MoldUDP64 header parser; sits in the 250 MHz domain after slow_fast_cdc.
- Accepts a byte stream with explicit frame-last, filters up to NUM_CH UDP destination ports (channels), and tracks a MoldUDP64 sequence number per channel.
- Drops duplicate packets and splits payload into framed ITCH messages tagged with channel id.
- Reports gaps with a lost-message count.

Parameters:
- NUM_CH, 2, number of accepted UDP destination ports/channels (1..8).
- CH_PORTS, {16'd26401,16'd26400}, packed NUM_CH*16 vector; channel i port = CH_PORTS[16i+:16].
- CHECK_ETHERTYPE, 1'b1, when 1 require ethertype 0x0800; when 0 skip that check.
- Local CH_W = max(1, clog2(NUM_CH)).

Ports:
- clkIn  in  1  250 MHz clock.
- rstIn  in  1  synchronous, active-high reset.
- dataIn  in  8  frame byte; first byte = dst MAC byte 0 (preamble/SFD already stripped).
- dataValidIn  in  1  byte qualifier; may have arbitrary gaps.
- dataLastIn  in  1  qualifies last byte of frame (with dataValidIn).
- dataErrIn  in  1  qualified error; frame is corrupt.
- itchDataValidOut  out  1  message byte valid.
- itchDataOut  out  8  message byte.
- itchStartOut  out  1  first byte of message.
- itchEndOut  out  1  last byte of message.
- itchErrOut  out  1  one-cycle pulse: current message truncated/corrupt, discard it.
- itchChOut  out  CH_W  channel index of output byte.
- packetLostOut  out  1  one-cycle pulse: sequence gap detected.
- lostCountOut  out  16  gap size, valid with packetLostOut, saturates at 0xFFFF.
- droppedPktsOut  out  16  saturating count of filtered/malformed frames.

Behaviour:
- All outputs registered; every output resets to 0. Per-channel expSeq (64b) and seen flag also reset to 0.
- Reset mid-frame returns FSM to HDR and discards the rest of that frame. The next byte after reset is treated as frame byte 0.
- Header counter: 6-bit, bytes 0..61.
  - 12-13: ethertype, must be 0x0800 if CHECK_ETHERTYPE.
  - 14: must be 0x45.
  - 23: must be 17.
  - 36-37: UDP dst port, matched against CH_PORTS (lowest index wins).
  - 52-59: sequence number, big-endian.
  - 60-61: message count, big-endian.
- FSM states: HDR, LEN_HI, LEN_LO, BODY, SKIP.
  - HDR: a check failure at its byte -> SKIP, and droppedPkts+1 (saturating).
  - Decision taken on the accepted byte 61, using the incoming count byte combinationally; ch = matched channel.
    - count==0xFFFF (end of session): no update -> SKIP.
    - !seen[ch] or seq==expSeq: accept; expSeq=seq+count; seen=1.
    - seq>expSeq: accept; packetLostOut=1, lostCountOut=min(seq-expSeq,0xFFFF), lostCh = ch on itchChOut that cycle; expSeq=seq+count.
    - seq<expSeq: duplicate -> SKIP, no outputs, expSeq unchanged, not counted as dropped.
    - Accepted with count==0 (heartbeat): -> SKIP after updating expSeq.
    - Otherwise -> LEN_HI, with msgRemain=count.
  - LEN_HI/LEN_LO: capture 16-bit length L.
    - L==0: decrement msgRemain; -> LEN_HI, or SKIP if msgRemain reaches 0.
    - Else -> BODY.
  - BODY: each accepted byte is output 1 cycle later with itchDataValidOut=1.
    - First byte asserts itchStartOut; byte L asserts itchEndOut (both when L==1).
    - After byte L, decrement msgRemain; -> LEN_HI if nonzero, else SKIP.
  - SKIP: discard bytes (padding, FCS) until dataLastIn -> HDR.
- dataLastIn or dataErrIn on a byte:
  - In HDR: -> HDR next frame, droppedPkts+1.
  - In BODY before byte L, or in LEN_*: itchErrOut pulses 1 cycle later; no itchEndOut for that message; -> HDR (if last) or SKIP (if err without last).
  - In SKIP: -> HDR on last.
  - An errored frame never updates expSeq unless the decision was already taken.
- dataLastIn on a byte that completes a message is normal; the next frame starts in HDR.
- Latency: input byte to itchData: 1 cycle. Byte 61 to packetLostOut: 1 cycle.
- No backpressure; the block sustains one byte per cycle.

Test Plan:
- Ch0 (port 26400) packet seq=1, count=2, messages L=3 {AA BB CC} and L=1 {DD} -> 4 output bytes, ch=0; start on AA and DD; end on CC and DD; expSeq0=3.
- Next ch0 packet seq=7, count=1 -> packetLostOut pulse, lostCountOut=4, message output, expSeq0=8.
- Replay seq=3 on ch0 -> no itch outputs, droppedPktsOut unchanged, expSeq0 stays 8.
- Interleave ch1 (port 26401) seq=100 first packet -> accepted without loss pulse, itchChOut=1; ch0 state unaffected.
- Ethertype 0x86DD, then UDP port 1234, then IHL=0x46 -> three drops, droppedPktsOut=3, no outputs.
- dataLastIn at body byte 2 of an L=5 message -> itchErrOut pulse, no itchEndOut. Following valid frame parses correctly.
- Assert rstIn mid-body -> all outputs 0 next cycle, seen flags cleared.
